// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch target unit and its BTB.
// Holds the control-flow kind encoding, the default-configuration BTB
// entry layout and the index/tag slicing helpers used by the BTB.
package branch_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned BTB_DEPTH_DEF = 16;
  localparam int unsigned IALIGN_DEF    = 4;
  localparam int unsigned OFFS_DEF      = $clog2(IALIGN_DEF);
  localparam int unsigned IW_DEF        = $clog2(BTB_DEPTH_DEF);
  localparam int unsigned TAGW_DEF      = XLEN_DEF - IW_DEF - OFFS_DEF;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_BRANCH = 2'b01,
    BR_JAL    = 2'b10,
    BR_JALR   = 2'b11
  } br_kind_t;

  // Entry layout for the default configuration.
  typedef struct packed {
    logic                valid;
    logic [TAGW_DEF-1:0] tag;
    logic [XLEN_DEF-1:0] target;
  } btb_entry_t;

  // BTB set index: pc[iw+offs-1:offs].
  function automatic int unsigned btb_index(input logic [63:0] pc,
                                            input int unsigned iw,
                                            input int unsigned offs);
    logic [63:0] mask;
    mask = (64'd1 << iw) - 64'd1;
    return 32'((pc >> offs) & mask);
  endfunction

  // BTB tag: everything above the index bits.
  function automatic logic [63:0] btb_tag(input logic [63:0] pc,
                                          input int unsigned iw,
                                          input int unsigned offs);
    return pc >> (iw + offs);
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer.
// Ports: clk/rst (sync, active-high) clear all valid bits; stall blocks
// updates; upd_* are the registered MEM-stage results (write on redirect,
// invalidate on a matching not-taken branch); lookup_pc -> hit/pred_target
// is purely combinational and sees pre-edge contents.
module btb_dm
  import branch_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IALIGN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            upd_valid,
  input  logic            upd_redirect,
  input  logic            upd_misalign,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] pred_target
);

  localparam int unsigned OFFS = $clog2(IALIGN);
  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned TAGW = XLEN - IW - OFFS;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] target;
  } payload_t;

  logic [DEPTH-1:0] valid_q;
  payload_t         entries_q [DEPTH];

  logic [IW-1:0]   upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic [IW-1:0]   lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            wr_en;
  logic            inv_en;
  payload_t        lk_entry;

  assign upd_idx = IW'(btb_index(64'(upd_pc), IW, OFFS));
  assign upd_tag = TAGW'(btb_tag(64'(upd_pc), IW, OFFS));
  assign lk_idx  = IW'(btb_index(64'(lookup_pc), IW, OFFS));
  assign lk_tag  = TAGW'(btb_tag(64'(lookup_pc), IW, OFFS));

  // A valid, aligned MEM instruction without redirect is a not-taken branch.
  assign wr_en  = !stall && upd_valid && upd_redirect && !upd_misalign;
  assign inv_en = !stall && upd_valid && !upd_redirect && !upd_misalign &&
                  (entries_q[upd_idx].tag == upd_tag);

  // Valid bits: reset clears everything, write sets, invalidate clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
    end else if (inv_en) begin
      valid_q[upd_idx] <= 1'b0;
    end
  end

  // Tag/target storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      entries_q[upd_idx] <= '{tag: upd_tag, target: upd_target};
    end
  end

  // Combinational lookup for the fetch stage.
  always_comb begin
    lk_entry    = entries_q[lk_idx];
    hit         = valid_q[lk_idx] && (lk_entry.tag == lk_tag);
    pred_target = hit ? lk_entry.target : '0;
  end

endmodule

// File: rtl/branch_target_unit.sv
// Branch/JAL/JALR target generation with an EX/MEM pipeline register and a
// direct-mapped BTB for next-PC prediction.
// Ports: CLK, RST (sync, active-high); ex_* EX-stage instruction inputs;
// stall/flush control the EX/MEM register; mem_* registered resolution
// (valid, redirect, target, pc, misalign); if_pc -> if_hit/if_pred_target
// combinational BTB lookup.
module branch_target_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned BTB_DEPTH = BTB_DEPTH_DEF,
  parameter int unsigned IALIGN    = IALIGN_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ex_valid,
  input  br_kind_t        ex_kind,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm_b,
  input  logic [XLEN-1:0] ex_imm_j,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            stall,
  input  logic            flush,
  output logic            mem_valid,
  output logic            mem_redirect,
  output logic [XLEN-1:0] mem_target,
  output logic [XLEN-1:0] mem_pc,
  output logic            mem_misalign,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_hit,
  output logic [XLEN-1:0] if_pred_target
);

  localparam int unsigned OFFS = $clog2(IALIGN);

  logic [XLEN-1:0] tgt_branch;
  logic [XLEN-1:0] tgt_jal;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] sel_target;
  logic            taken;
  logic            misalign;
  logic            redirect;

  // Target arithmetic wraps modulo 2^XLEN.
  assign tgt_branch = ex_pc + ex_imm_b;
  assign tgt_jal    = ex_pc + ex_imm_j;
  assign jalr_sum   = ex_rs1 + ex_imm_i;

  // Kind select; misalignment only matters for taken transfers and
  // suppresses the redirect so the trap path owns it.
  always_comb begin
    sel_target = '0;
    taken      = 1'b0;
    unique case (ex_kind)
      BR_NONE: begin
        sel_target = '0;
        taken      = 1'b0;
      end
      BR_BRANCH: begin
        sel_target = tgt_branch;
        taken      = ex_taken;
      end
      BR_JAL: begin
        sel_target = tgt_jal;
        taken      = 1'b1;
      end
      BR_JALR: begin
        sel_target = {jalr_sum[XLEN-1:1], 1'b0};
        taken      = 1'b1;
      end
    endcase
    misalign = taken && (|sel_target[OFFS-1:0]);
    redirect = ex_valid && taken && !misalign;
  end

  // EX/MEM register: RST > flush > stall > load.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      mem_valid    <= 1'b0;
      mem_redirect <= 1'b0;
      mem_target   <= '0;
      mem_pc       <= '0;
      mem_misalign <= 1'b0;
    end else if (!stall) begin
      mem_valid    <= ex_valid && (ex_kind != BR_NONE);
      mem_redirect <= redirect;
      mem_target   <= sel_target;
      mem_pc       <= ex_pc;
      mem_misalign <= misalign;
    end
  end

  btb_dm #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH),
    .IALIGN(IALIGN)
  ) u_btb (
    .clk         (CLK),
    .rst         (RST),
    .stall       (stall),
    .upd_valid   (mem_valid),
    .upd_redirect(mem_redirect),
    .upd_misalign(mem_misalign),
    .upd_pc      (mem_pc),
    .upd_target  (mem_target),
    .lookup_pc   (if_pc),
    .hit         (if_hit),
    .pred_target (if_pred_target)
  );

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit: directed scenarios followed by
// randomized traffic, compared against an arithmetic reference model.
module tb_branch_target_unit;
  import branch_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IAL   = 4;
  localparam longint unsigned MOD = 64'd1 << 32;

  logic        CLK;
  logic        RST;
  logic        ex_valid;
  br_kind_t    ex_kind;
  logic        ex_taken;
  logic [31:0] ex_pc, ex_rs1, ex_imm_b, ex_imm_j, ex_imm_i;
  logic        stall, flush;
  logic        mem_valid, mem_redirect, mem_misalign;
  logic [31:0] mem_target, mem_pc;
  logic [31:0] if_pc;
  logic        if_hit;
  logic [31:0] if_pred_target;

  branch_target_unit dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_imm_b(ex_imm_b), .ex_imm_j(ex_imm_j), .ex_imm_i(ex_imm_i),
    .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_redirect(mem_redirect),
    .mem_target(mem_target), .mem_pc(mem_pc), .mem_misalign(mem_misalign),
    .if_pc(if_pc), .if_hit(if_hit), .if_pred_target(if_pred_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit              m_valid, m_redir, m_mis;
  longint unsigned m_target, m_pc;
  bit              bv   [DEPTH];
  longint unsigned btag [DEPTH];
  longint unsigned btgt [DEPTH];

  logic [31:0] pool [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic longint unsigned bidx(input longint unsigned pc);
    return (pc / IAL) % DEPTH;
  endfunction

  function automatic longint unsigned btg(input longint unsigned pc);
    return pc / (IAL * DEPTH);
  endfunction

  task automatic model_clear_mem();
    m_valid = 0; m_redir = 0; m_mis = 0; m_target = 0; m_pc = 0;
  endtask

  task automatic idle();
    RST = 0; stall = 0; flush = 0;
    ex_valid = 0; ex_kind = BR_NONE; ex_taken = 0;
    ex_pc = 0; ex_rs1 = 0; ex_imm_b = 0; ex_imm_j = 0; ex_imm_i = 0;
  endtask

  task automatic set_ex(input br_kind_t k, input logic t, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] ib,
                        input logic [31:0] ij, input logic [31:0] ii);
    idle();
    ex_valid = 1; ex_kind = k; ex_taken = t; ex_pc = pc; ex_rs1 = rs1;
    ex_imm_b = ib; ex_imm_j = ij; ex_imm_i = ii;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_hit, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, "_hit"}, 64'(if_hit), 64'(exp_hit));
    check({tag, "_pred"}, 64'(if_pred_target), 64'(exp_tgt));
  endtask

  // One clock: check lookup, advance model, check registered outputs.
  task automatic cycle();
    longint unsigned i, t;
    bit taken, mis, eh;
    #1;
    i  = bidx(if_pc);
    eh = bv[i] && (btag[i] == btg(if_pc));
    check("if_hit", 64'(if_hit), 64'(eh));
    check("if_pred_target", 64'(if_pred_target), eh ? btgt[i] : 64'd0);

    t = 0; taken = 0;
    case (ex_kind)
      BR_BRANCH: begin t = (ex_pc + ex_imm_b) % MOD; taken = ex_taken; end
      BR_JAL:    begin t = (ex_pc + ex_imm_j) % MOD; taken = 1; end
      BR_JALR:   begin t = (ex_rs1 + ex_imm_i) % MOD; t = t - (t % 2); taken = 1; end
      default:   begin t = 0; taken = 0; end
    endcase
    mis = taken && ((t % IAL) != 0);

    if (RST) begin
      model_clear_mem();
      for (int k = 0; k < DEPTH; k++) bv[k] = 0;
    end else begin
      if (!stall && m_valid && !m_mis) begin
        i = bidx(m_pc);
        if (m_redir) begin
          bv[i] = 1; btag[i] = btg(m_pc); btgt[i] = m_target;
        end else if (btag[i] == btg(m_pc)) begin
          bv[i] = 0;
        end
      end
      if (flush) model_clear_mem();
      else if (!stall) begin
        m_valid  = ex_valid && (ex_kind != BR_NONE);
        m_redir  = ex_valid && taken && !mis;
        m_target = t;
        m_pc     = ex_pc;
        m_mis    = mis;
      end
    end

    @(posedge CLK);
    #1;
    check("mem_valid", 64'(mem_valid), 64'(m_valid));
    check("mem_redirect", 64'(mem_redirect), 64'(m_redir));
    check("mem_target", 64'(mem_target), m_target);
    check("mem_pc", 64'(mem_pc), m_pc);
    check("mem_misalign", 64'(mem_misalign), 64'(m_mis));
  endtask

  initial begin
    pool[0] = 32'h100;  pool[1] = 32'h140;  pool[2] = 32'h180;  pool[3] = 32'h2000;
    pool[4] = 32'h2040; pool[5] = 32'h3008; pool[6] = 32'hFFFFFFFC; pool[7] = 32'h1000;
    for (int k = 0; k < DEPTH; k++) begin bv[k] = 0; btag[k] = 0; btgt[k] = 0; end
    model_clear_mem();
    idle();
    if_pc = 0;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_target", 64'(mem_target), 64'd0);
    lookup("rst", 32'h100, 1'b0, 32'h0);

    // 1: taken branch backwards, then BTB hit
    set_ex(BR_BRANCH, 1, 32'h100, 0, 32'hFFFFFFF0, 0, 0);
    cycle();
    check("t1_target", 64'(mem_target), 64'h0F0);
    check("t1_redirect", 64'(mem_redirect), 64'd1);
    idle(); cycle();
    lookup("t1", 32'h100, 1'b1, 32'h0F0);

    // 2: JALR aligned, then misaligned (no BTB write)
    set_ex(BR_JALR, 0, 32'h1000, 32'h2001, 0, 0, 32'd4);
    cycle();
    check("t2a_target", 64'(mem_target), 64'h2004);
    check("t2a_misalign", 64'(mem_misalign), 64'd0);
    set_ex(BR_JALR, 0, 32'h1004, 32'h2002, 0, 0, 32'd0);
    cycle();
    check("t2b_target", 64'(mem_target), 64'h2002);
    check("t2b_misalign", 64'(mem_misalign), 64'd1);
    check("t2b_redirect", 64'(mem_redirect), 64'd0);
    idle(); cycle();
    lookup("t2_mis", 32'h1004, 1'b0, 32'h0);
    lookup("t2_ok", 32'h1000, 1'b1, 32'h2004);

    // 3: JAL wrap
    set_ex(BR_JAL, 0, 32'hFFFFFFFC, 0, 0, 32'd8, 0);
    cycle();
    check("t3_target", 64'(mem_target), 64'h4);
    check("t3_redirect", 64'(mem_redirect), 64'd1);

    // 4: stall holds, flush beats stall
    for (int k = 0; k < 2; k++) begin
      set_ex(BR_BRANCH, 1, 32'h500 + 32'(k * 8), 0, 32'h40, 0, 0);
      stall = 1;
      cycle();
      check("t4_hold_target", 64'(mem_target), 64'h4);
      check("t4_hold_pc", 64'(mem_pc), 64'hFFFFFFFC);
    end
    stall = 1; flush = 1;
    cycle();
    check("t4_flush_valid", 64'(mem_valid), 64'd0);
    check("t4_flush_redirect", 64'(mem_redirect), 64'd0);

    // 5: aliasing at index 0, then not-taken invalidation
    set_ex(BR_BRANCH, 1, 32'h100, 0, 32'hFFFFFF80, 0, 0); cycle();
    set_ex(BR_BRANCH, 1, 32'h140, 0, 32'h0C0, 0, 0);      cycle();
    idle(); cycle();
    lookup("t5_alias_old", 32'h100, 1'b0, 32'h0);
    lookup("t5_alias_new", 32'h140, 1'b1, 32'h200);
    set_ex(BR_BRANCH, 0, 32'h140, 0, 32'h0C0, 0, 0); cycle();
    idle(); cycle();
    lookup("t5_inval", 32'h140, 1'b0, 32'h0);

    // 6: populate entries, reset with an in-flight MEM entry
    set_ex(BR_BRANCH, 1, 32'h100, 0, 32'hFFFFFF80, 0, 0); cycle();
    set_ex(BR_JAL, 0, 32'h2000, 0, 0, 32'h100, 0);        cycle();
    set_ex(BR_JALR, 0, 32'h3008, 32'h400, 0, 0, 0);       cycle();
    set_ex(BR_JAL, 0, 32'h4000, 0, 0, 32'h10, 0);         cycle();
    lookup("t6_pre", 32'h2000, 1'b1, 32'h2100);
    set_ex(BR_JAL, 0, 32'h140, 0, 0, 32'h20, 0);
    RST = 1;
    cycle();
    check("t6_mem_valid", 64'(mem_valid), 64'd0);
    check("t6_mem_target", 64'(mem_target), 64'd0);
    check("t6_mem_pc", 64'(mem_pc), 64'd0);
    idle();
    lookup("t6_a", 32'h100, 1'b0, 32'h0);
    lookup("t6_b", 32'h140, 1'b0, 32'h0);
    lookup("t6_c", 32'h2000, 1'b0, 32'h0);
    cycle();
    lookup("t6_d", 32'h4000, 1'b0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      RST      = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      ex_valid = ($urandom_range(0, 7) != 0);
      ex_kind  = br_kind_t'(2'($urandom_range(0, 3)));
      ex_taken = 1'($urandom_range(0, 1));
      ex_pc    = pool[$urandom_range(0, 7)];
      ex_rs1   = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
      ex_imm_b = 32'($urandom_range(0, 255) * 2) - 32'd256;
      ex_imm_j = 32'($urandom_range(0, 255) * 2) - 32'd256;
      ex_imm_i = 32'($urandom_range(0, 15)) - 32'd8;
      if_pc    = pool[$urandom_range(0, 7)];
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
Parametrised successor to the combinational branch address generator, built for the pipelined OTTER.
- EX side: computes branch, JAL and JALR targets from one selected control-flow kind, then registers the result into the EX/MEM boundary with stall and flush.
- Misalignment: flags target misalignment.
- Prediction: maintains a direct-mapped branch target buffer (BTB) that the IF stage queries combinationally for next-PC prediction.

Parameters:
- XLEN, 32, datapath/address width.
- BTB_DEPTH, 16, BTB entries; power of two, ≥2.
- IALIGN, 4, instruction alignment in bytes; 4 or 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_kind  in  2  br_kind_t: 00 NONE, 01 BRANCH, 10 JAL, 11 JALR.
- ex_taken  in  1  branch condition result; ignored unless BRANCH.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_rs1  in  XLEN  forwarded rs1 value.
- ex_imm_b / ex_imm_j / ex_imm_i  in  XLEN  sign-extended B/J/I immediates.
- stall  in  1  hold EX/MEM register.
- flush  in  1  bubble EX/MEM register.
- mem_valid  out  1  registered: control-flow instruction resolved.
- mem_redirect  out  1  registered: redirect fetch to mem_target.
- mem_target  out  XLEN  registered selected target.
- mem_pc  out  XLEN  registered ex_pc.
- mem_misalign  out  1  registered: target not IALIGN-aligned.
- if_pc  in  XLEN  current fetch PC.
- if_hit  out  1  combinational BTB hit for if_pc.
- if_pred_target  out  XLEN  predicted target; 0 when no hit.

Behaviour:
- Targets are computed combinationally, modulo 2^XLEN with wrap and no overflow flag:
  - branch = pc + imm_b
  - jal = pc + imm_j
  - jalr = (rs1 + imm_i) with bit0 forced to 0
- Target select by ex_kind. NONE selects target 0 and redirect 0.
- Taken logic is combinational: BRANCH uses ex_taken; JAL and JALR are always taken.
- Misalignment is combinational:
  - IALIGN=4: the selected target has target[1:0] ≠ 0.
  - IALIGN=2: target[0] ≠ 0, which can never occur for JALR.
  - It is evaluated only for taken instructions.
  - When set, redirect is forced to 0 (the trap path handles it).
- EX/MEM register: latency 1 cycle. Priority at each posedge is RST > flush > stall > load.
  - RST: all mem_* outputs go to 0.
  - flush: mem_valid and mem_redirect go to 0; flush wins over a simultaneous stall. Other fields are don't-care but are cleared.
  - stall: all mem_* outputs hold.
  - load: mem_valid = ex_valid && kind ≠ NONE. The other fields are captured.
- BTB organisation:
  - OFFS = log2(IALIGN), IW = log2(BTB_DEPTH).
  - index = pc[IW+OFFS-1:OFFS]; tag = pc[XLEN-1:IW+OFFS].
  - Each entry holds {valid, tag, target}.
- BTB update, acting on registered MEM-stage values and only when !stall:
  - mem_valid && mem_redirect writes {1, tag(mem_pc), mem_target} at index(mem_pc), overwriting any alias.
  - A not-taken BRANCH in MEM (mem_valid, !mem_redirect, !mem_misalign) whose tag matches the entry clears that entry's valid bit.
  - A misaligned instruction never updates.
- BTB lookup, combinational: if_hit = valid[idx] && tag match.
  - A same-cycle update is not visible until after the clock edge, so lookup sees old contents.
- Reset: RST clears all valid bits in the same edge. Tag and target storage is not reset. if_hit = 0 for every if_pc from the cycle after RST until the next update.
- Reset asserted mid-operation discards any in-flight MEM entry; no BTB write occurs on the RST edge.

Decomposition:
- Package branch_pkg:
  - br_kind_t enum (NONE, BRANCH, JAL, JALR).
  - btb_entry_t struct parametrised via localparams.
  - Helper functions for index/tag slicing.
- Sub-module btb_dm holds the direct-mapped BTB storage with its lookup/update/invalidate logic. The top holds target arithmetic and the EX/MEM register.

Test Plan:
1. BRANCH pc=0x100, imm_b=0xFFFFFFF0, taken=1 → next cycle mem_target=0xF0, mem_redirect=1. One cycle later if_pc=0x100 → if_hit=1, if_pred_target=0xF0.
2. JALR rs1=0x2001, imm_i=4 → mem_target=0x2004, redirect=1, misalign=0. Then rs1=0x2002, imm_i=0 → target 0x2002, misalign=1, redirect=0, no BTB write for pc.
3. JAL pc=0xFFFFFFFC, imm_j=8 → mem_target=0x00000004, redirect=1 (wrap).
4. stall held 2 cycles with changing EX inputs → mem_* unchanged. flush+stall together → mem_valid=0, mem_redirect=0 next cycle.
5. DEPTH=16: taken branches at 0x100→0x80, then 0x140→0x200 (same index 0) → if_pc=0x100 misses, 0x140 hits 0x200. A not-taken BRANCH at 0x140 → 0x140 misses.
6. Populate 3 BTB entries, assert RST one cycle mid-stream → all mem_* = 0, if_hit=0 for 0x100, 0x140, 0x2000.
